// File: rtl/selection_if.sv
// ---------------------------------------------------------------------------
// selection_if
// Bundles the start/done handshake and the wide data buses between the GA
// population source, the selection stage and the mutation stage.
//
// Handshake: the master raises start while the slave is idle; the slave
// captures population/fitness on that edge, so the master may change them
// right afterwards. start is ignored while a pass is in flight (no queuing).
// done is a one-cycle pulse; sel_population/best_fit are valid during it
// and hold their value until the next pass completes.
//
// Signals:
//   start          master -> slave  begin a selection pass
//   population     master -> slave  NUM_PATHS paths, path 0 in the MSBs
//   fitness        master -> slave  NUM_PATHS fitness values, index 0 in the MSBs
//   sel_population slave  -> master NUM_SEL ranked paths, rank 0 in the MSBs
//   best_fit       slave  -> master fitness of rank 0
//   done           slave  -> master one-cycle completion pulse
// ---------------------------------------------------------------------------
interface selection_if #(
    parameter int NUM_PATHS = 50,
    parameter int NUM_SEL   = 10,
    parameter int PATH_W    = 150,
    parameter int FIT_W     = 16
);
    logic                        start;
    logic [NUM_PATHS*PATH_W-1:0] population;
    logic [NUM_PATHS*FIT_W-1:0]  fitness;
    logic [NUM_SEL*PATH_W-1:0]   sel_population;
    logic [FIT_W-1:0]            best_fit;
    logic                        done;

    modport master (
        output start, population, fitness,
        input  sel_population, best_fit, done
    );

    modport slave (
        input  start, population, fitness,
        output sel_population, best_fit, done
    );
endinterface

// File: rtl/selection.sv
// ---------------------------------------------------------------------------
// selection
// Elitist selection stage of the GA. A pass latches the whole population and
// its fitness values, then streams the candidates one per cycle through an
// insertion-sorted list of the NUM_SEL fittest paths (lowest fitness first).
// When the last candidate has been processed the list is published on
// sel_population/best_fit and done pulses for one cycle.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   bus        selection_if slave modport (start/population/fitness in,
//              sel_population/best_fit/done out)
//   state_dbg  current FSM state (0 IDLE, 1 SCAN, 2 DONE)
// ---------------------------------------------------------------------------
module selection #(
    parameter int NUM_PATHS = 50,
    parameter int NUM_SEL   = 10,
    parameter int PATH_W    = 150,
    parameter int FIT_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    selection_if.slave  bus,
    output logic [1:0]  state_dbg
);

    localparam int IDX_W = $clog2(NUM_PATHS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATHS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]  idx_q;

    // Private copy of the population so the source can move on after start.
    logic [PATH_W-1:0] pop_q [NUM_PATHS];
    logic [FIT_W-1:0]  fit_q [NUM_PATHS];

    // Ranked list, slot 0 is the best so far.
    logic [PATH_W-1:0]  slot_path_q [NUM_SEL];
    logic [PATH_W-1:0]  slot_path_d [NUM_SEL];
    logic [FIT_W-1:0]   slot_fit_q  [NUM_SEL];
    logic [FIT_W-1:0]   slot_fit_d  [NUM_SEL];
    logic [NUM_SEL-1:0] slot_valid_q;
    logic [NUM_SEL-1:0] slot_valid_d;
    logic [NUM_SEL-1:0] ins;

    logic [PATH_W-1:0] cand_path;
    logic [FIT_W-1:0]  cand_fit;

    assign cand_path = pop_q[idx_q];
    assign cand_fit  = fit_q[idx_q];

    assign state_dbg = state_q;
    assign bus.done  = (state_q == DONE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SCAN;
            SCAN:    if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- insertion network ----------------
    // ins[s] says the candidate beats slot s. Because valid slots are packed
    // at the top and sorted ascending, ins is monotone: once set it stays set
    // for every worse slot. The insertion point is the first set bit; slots
    // below it take their upper neighbour, which makes the last slot fall off.
    // The strict compare keeps earlier indices ahead on ties.
    always_comb begin
        for (int s = 0; s < NUM_SEL; s++) begin
            ins[s] = !slot_valid_q[s] || (cand_fit < slot_fit_q[s]);
        end

        for (int s = 0; s < NUM_SEL; s++) begin
            slot_path_d[s]  = slot_path_q[s];
            slot_fit_d[s]   = slot_fit_q[s];
            slot_valid_d[s] = slot_valid_q[s];
        end

        if (ins[0]) begin
            slot_path_d[0]  = cand_path;
            slot_fit_d[0]   = cand_fit;
            slot_valid_d[0] = 1'b1;
        end

        for (int s = 1; s < NUM_SEL; s++) begin
            if (ins[s]) begin
                if (!ins[s-1]) begin
                    slot_path_d[s]  = cand_path;
                    slot_fit_d[s]   = cand_fit;
                    slot_valid_d[s] = 1'b1;
                end else begin
                    slot_path_d[s]  = slot_path_q[s-1];
                    slot_fit_d[s]   = slot_fit_q[s-1];
                    slot_valid_d[s] = slot_valid_q[s-1];
                end
            end
        end
    end

    // ---------------- data storage (no reset needed) ----------------
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.start) begin
            for (int i = 0; i < NUM_PATHS; i++) begin
                pop_q[i] <= bus.population[NUM_PATHS*PATH_W-1-PATH_W*i -: PATH_W];
                fit_q[i] <= bus.fitness[NUM_PATHS*FIT_W-1-FIT_W*i -: FIT_W];
            end
        end
        if (state_q == SCAN) begin
            for (int s = 0; s < NUM_SEL; s++) begin
                slot_path_q[s] <= slot_path_d[s];
                slot_fit_q[s]  <= slot_fit_d[s];
            end
        end
    end

    // ---------------- control and published result ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q              <= '0;
            slot_valid_q       <= '0;
            bus.sel_population <= '0;
            bus.best_fit       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        idx_q        <= '0;
                        slot_valid_q <= '0;
                    end
                end
                SCAN: begin
                    slot_valid_q <= slot_valid_d;
                    idx_q        <= idx_q + IDX_W'(1);
                    // Publish straight from the network so the last
                    // candidate is included without an extra cycle.
                    if (idx_q == LAST_IDX) begin
                        for (int r = 0; r < NUM_SEL; r++) begin
                            bus.sel_population[NUM_SEL*PATH_W-1-PATH_W*r -: PATH_W] <= slot_path_d[r];
                        end
                        bus.best_fit <= slot_fit_d[0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_selection.sv
// ---------------------------------------------------------------------------
// tb_selection
// Drives selection passes with directed and random fitness tables and checks
// the ranked output against a reference that repeatedly picks the lowest
// remaining fitness (lowest index on ties).
// ---------------------------------------------------------------------------
module tb_selection;

    localparam int NP = 50;
    localparam int NS = 10;
    localparam int PW = 150;
    localparam int FW = 16;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    selection_if #(.NUM_PATHS(NP), .NUM_SEL(NS), .PATH_W(PW), .FIT_W(FW)) bus ();

    selection #(.NUM_PATHS(NP), .NUM_SEL(NS), .PATH_W(PW), .FIT_W(FW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [PW-1:0]    path_a [NP];
    logic [FW-1:0]    fit_a  [NP];
    logic [PW-1:0]    exp_q[$];
    logic [FW-1:0]    exp_fit_q[$];
    logic [NS*PW-1:0] last_sel;
    logic [FW-1:0]    last_best;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [PW-1:0] rand_path();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[PW-1:0];
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < NP; i++) begin
            path_a[i] = rand_path();
            case (mode)
                0:       fit_a[i] = FW'(i);
                1:       fit_a[i] = FW'(NP - 1 - i);
                2:       fit_a[i] = 16'h1234;
                3:       fit_a[i] = 16'hFFFF;
                4:       fit_a[i] = FW'($urandom_range(0, 15));
                6:       fit_a[i] = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'hFFFE;
                default: fit_a[i] = FW'($urandom());
            endcase
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NP; i++) begin
            bus.population[NP*PW-1-PW*i -: PW] = path_a[i];
            bus.fitness[NP*FW-1-FW*i -: FW]    = fit_a[i];
        end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < NP; i++) begin
            bus.population[NP*PW-1-PW*i -: PW] = rand_path();
            bus.fitness[NP*FW-1-FW*i -: FW]    = 16'h0000;
        end
    endtask

    // Reference: take the minimum remaining fitness NS times, lowest index
    // winning ties.
    task automatic model_push();
        bit used [NP];
        int best;
        for (int i = 0; i < NP; i++) used[i] = 1'b0;
        for (int r = 0; r < NS; r++) begin
            best = -1;
            for (int i = 0; i < NP; i++) begin
                if (!used[i] && (best < 0 || fit_a[i] < fit_a[best])) best = i;
            end
            used[best] = 1'b1;
            exp_q.push_back(path_a[best]);
            if (r == 0) exp_fit_q.push_back(fit_a[best]);
        end
    endtask

    task automatic check_result();
        logic [PW-1:0] e;
        logic [FW-1:0] ef;
        for (int r = 0; r < NS; r++) begin
            e = exp_q.pop_front();
            check($sformatf("rank%0d", r), bus.sel_population[NS*PW-1-PW*r -: PW], e);
            last_sel[NS*PW-1-PW*r -: PW] = e;
        end
        ef = exp_fit_q.pop_front();
        check("best_fit", bus.best_fit, ef);
        last_best = ef;
    endtask

    task automatic flush();
        exp_q.delete();
        exp_fit_q.delete();
    endtask

    // One pass; optionally disturbs inputs and pulses start mid-scan.
    task automatic run_pass(input int mode, input bit disturb);
        bit got;
        int lat;
        fill(mode);
        drive_inputs();
        model_push();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 60 && !got; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                got = 1'b1;
                lat = c;
            end else begin
                if (c == 25) begin
                    check("hold_sel", bus.sel_population, last_sel);
                    check("hold_best", bus.best_fit, last_best);
                end
                if (disturb && c == 10) begin
                    bus.start = 1'b1;
                    scramble_inputs();
                end
                if (disturb && c == 11) bus.start = 1'b0;
            end
        end
        // done must be up in the cycle after edge k+50.
        check($sformatf("done_latency_m%0d", mode), lat, 50);
        if (got) begin
            check_result();
            @(posedge clk); #1;
            check("done_pulse", bus.done, 1'b0);
        end else begin
            flush();
        end
    endtask

    task automatic reset_mid_scan();
        int cnt;
        fill(0);
        drive_inputs();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_sel", bus.sel_population, '0);
        check("rst_best", bus.best_fit, '0);
        check("rst_done", bus.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        last_sel  = '0;
        last_best = '0;
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (bus.done) cnt++;
        end
        check("rst_no_done", cnt, 0);
        check("rst_idle_sel", bus.sel_population, '0);
    endtask

    task automatic back_to_back();
        bit got;
        bit got2;
        int gap;
        int cnt;
        fill(5);
        drive_inputs();
        model_push();
        model_push();
        @(negedge clk);
        bus.start = 1'b1;
        got = 1'b0;
        for (int c = 1; c <= 60 && !got; c++) begin
            @(posedge clk); #1;
            if (bus.done) got = 1'b1;
        end
        check("b2b_first", got, 1'b1);
        if (got) begin
            check_result();
            got2 = 1'b0;
            gap  = 0;
            for (int c = 1; c <= 60 && !got2; c++) begin
                @(posedge clk); #1;
                if (bus.done) begin
                    got2 = 1'b1;
                    gap  = c;
                end
            end
            bus.start = 1'b0;
            check("b2b_gap", gap, 52);
            if (got2) check_result();
            else flush();
        end else begin
            bus.start = 1'b0;
            flush();
        end
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (bus.done) cnt++;
        end
        check("b2b_stop", cnt, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.population = '0;
        bus.fitness    = '0;
        last_sel       = '0;
        last_best      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sel", bus.sel_population, '0);
        check("reset_best", bus.best_fit, '0);
        check("reset_done", bus.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_pass(0, 1'b0);
        run_pass(1, 1'b0);
        run_pass(2, 1'b0);
        run_pass(3, 1'b0);
        run_pass(6, 1'b0);
        for (int n = 0; n < 4; n++) run_pass(4, 1'b0);
        for (int n = 0; n < 2; n++) run_pass(5, 1'b0);
        run_pass(4, 1'b1);
        reset_mid_scan();
        run_pass(1, 1'b0);
        back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
